// File: rtl/fwd_hazard_scoreboard.sv
// EX-stage forwarding and load-use hazard unit. It tracks in-flight destination
// writes in its own shift register and keeps a saturating count of stall cycles.
module fwd_hazard_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = $clog2(NUM_FWD + 1),
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid,
  input  logic [NUM_SRC*5-1:0]     ex_rs_addr,
  input  logic [NUM_SRC-1:0]       ex_rs_valid,
  input  logic [4:0]               ex_rd_addr,
  input  logic                     ex_rd_wr,
  input  logic                     ex_is_load,
  input  logic                     advance,
  input  logic                     flush,
  input  logic                     ld_data_ready,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     load_use_stall,
  output logic [CNT_W-1:0]         stall_count
);

  logic [NUM_FWD-1:0]      r_v;
  logic [NUM_FWD-1:0]      r_wr;
  logic [NUM_FWD-1:0]      r_ld;
  logic [NUM_FWD-1:0][4:0] r_rd;
  logic [CNT_W-1:0]        r_stall_cnt;

  logic [NUM_FWD-1:0]       w_live;
  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
  logic                     w_stall;
  logic                     w_rec;

  // Scanning from the oldest stage down lets the nearest live match overwrite older ones.
  function automatic logic [SEL_W-1:0] nearest_sel(
    input logic [4:0]              addr,
    input logic [NUM_FWD-1:0]      live,
    input logic [NUM_FWD-1:0][4:0] rd
  );
    logic [SEL_W-1:0] sel;
    sel = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (live[k] && rd[k] == addr) sel = SEL_W'(k + 1);
    end
    return sel;
  endfunction

  always_comb begin
    w_live = '0;
    for (int k = 0; k < NUM_FWD; k++) begin
      w_live[k] = r_v[k] & r_wr[k] & (r_rd[k] != 5'd0);
    end
  end

  always_comb begin
    w_fwd_sel = '0;
    w_stall   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_valid && ex_rs_valid[i] && ex_rs_addr[5*i +: 5] != 5'd0) begin
        w_fwd_sel[i*SEL_W +: SEL_W] = nearest_sel(ex_rs_addr[5*i +: 5], w_live, r_rd);
        if (nearest_sel(ex_rs_addr[5*i +: 5], w_live, r_rd) == SEL_W'(1) &&
            r_ld[0] && !ld_data_ready) begin
          w_stall = 1'b1;
        end
      end
    end
  end

  // A stalled or flushed EX instruction becomes a bubble in stage 0.
  assign w_rec = ex_valid & ~flush & ~w_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v         <= '0;
      r_wr        <= '0;
      r_ld        <= '0;
      r_rd        <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (advance) begin
        for (int k = NUM_FWD - 1; k >= 1; k--) begin
          r_v[k]  <= r_v[k-1];
          r_wr[k] <= r_wr[k-1];
          r_ld[k] <= r_ld[k-1];
          r_rd[k] <= r_rd[k-1];
        end
        r_v[0]  <= w_rec;
        r_wr[0] <= w_rec & ex_rd_wr;
        r_ld[0] <= w_rec & ex_is_load;
        r_rd[0] <= w_rec ? ex_rd_addr : 5'd0;
      end
      if (w_stall && r_stall_cnt != {CNT_W{1'b1}}) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign fwd_sel        = w_fwd_sel;
  assign load_use_stall = w_stall;
  assign stall_count    = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Bench for fwd_hazard_scoreboard: directed scenarios plus random traffic checked
// against a queue-based model of the in-flight write record.
module tb_fwd_hazard_scoreboard;
  localparam int NS = 2;
  localparam int NF = 2;
  localparam int SW = $clog2(NF + 1);
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, ex_valid, ex_rd_wr, ex_is_load, advance, flush, ld_data_ready;
  logic [NS*5-1:0] ex_rs_addr;
  logic [NS-1:0]   ex_rs_valid;
  logic [4:0]      ex_rd_addr;
  logic [NS*SW-1:0] fwd_sel, fwd_sel_s;
  logic            stall, stall_s;
  logic [CW-1:0]   cnt;
  logic [1:0]      cnt_s;

  fwd_hazard_scoreboard #(.NUM_SRC(NS), .NUM_FWD(NF), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rs_addr(ex_rs_addr),
    .ex_rs_valid(ex_rs_valid), .ex_rd_addr(ex_rd_addr), .ex_rd_wr(ex_rd_wr),
    .ex_is_load(ex_is_load), .advance(advance), .flush(flush),
    .ld_data_ready(ld_data_ready), .fwd_sel(fwd_sel), .load_use_stall(stall),
    .stall_count(cnt));

  fwd_hazard_scoreboard #(.NUM_SRC(NS), .NUM_FWD(NF), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rs_addr(ex_rs_addr),
    .ex_rs_valid(ex_rs_valid), .ex_rd_addr(ex_rd_addr), .ex_rd_wr(ex_rd_wr),
    .ex_is_load(ex_is_load), .advance(advance), .flush(flush),
    .ld_data_ready(ld_data_ready), .fwd_sel(fwd_sel_s), .load_use_stall(stall_s),
    .stall_count(cnt_s));

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } ent_t;

  ent_t tbl[$];
  int   m_cnt, m_cnt2;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    tbl.delete();
    for (int k = 0; k < NF; k++) tbl.push_back('0);
    m_cnt  = 0;
    m_cnt2 = 0;
  endtask

  function automatic int exp_sel(input int i);
    logic [4:0] a;
    a = ex_rs_addr[5*i +: 5];
    if (!(ex_valid && ex_rs_valid[i] && a != 0)) return 0;
    foreach (tbl[k]) begin
      if (tbl[k].v && tbl[k].wr && tbl[k].rd != 0 && tbl[k].rd == a) return k + 1;
    end
    return 0;
  endfunction

  function automatic int exp_stall();
    for (int i = 0; i < NS; i++) begin
      if (exp_sel(i) == 1 && tbl[0].ld && !ld_data_ready) return 1;
    end
    return 0;
  endfunction

  function automatic int sel_of(input logic [NS*SW-1:0] v, input int i);
    return int'(v[i*SW +: SW]);
  endfunction

  task automatic drive(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [1:0] rsv, input logic [4:0] rd, input logic wr,
                       input logic ld, input logic adv, input logic fl, input logic rdy);
    ex_valid      = vld;
    ex_rs_addr    = {rs2, rs1};
    ex_rs_valid   = rsv;
    ex_rd_addr    = rd;
    ex_rd_wr      = wr;
    ex_is_load    = ld;
    advance       = adv;
    flush         = fl;
    ld_data_ready = rdy;
    #2;
  endtask

  // Compare against the model, advance the model, then cross the clock edge.
  task automatic cycle(input bit do_chk);
    int   st;
    ent_t e;
    st = exp_stall();
    if (do_chk) begin
      for (int i = 0; i < NS; i++) begin
        check($sformatf("sel%0d", i), sel_of(fwd_sel, i), exp_sel(i));
        check($sformatf("sel%0d_s", i), sel_of(fwd_sel_s, i), exp_sel(i));
      end
      check("stall", int'(stall), st);
      check("stall_s", int'(stall_s), st);
      check("count", int'(cnt), m_cnt);
      check("count_s", int'(cnt_s), m_cnt2);
    end
    if (!rst_n) begin
      model_clear();
    end else begin
      if (advance) begin
        e = (ex_valid && !flush && st == 0) ? {1'b1, ex_rd_addr, ex_rd_wr, ex_is_load} : '0;
        tbl.push_front(e);
        void'(tbl.pop_back());
      end
      if (st != 0) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0;
    drive(1, 5, 5, 2'b11, 5, 1, 1, 1, 0, 0);
    cycle(0);
    // Table now cleared; outputs must be zero with arbitrary inputs under reset.
    drive(1, 5, 5, 2'b11, 5'($urandom), 1'($urandom), 1'($urandom), 1, 0, 0);
    check("rst_sel", int'(fwd_sel), 0);
    check("rst_stall", int'(stall), 0);
    check("rst_cnt", int'(cnt), 0);
    cycle(1);
    rst_n = 1'b1;

    // ADD x5, then two readers of x5 that do not write
    drive(1, 5, 5, 2'b11, 5, 1, 0, 1, 0, 1);
    check("empty_sel", int'(fwd_sel), 0);
    cycle(1);
    drive(1, 5, 5, 2'b11, 1, 0, 0, 1, 0, 1);
    check("add_s0_a", sel_of(fwd_sel, 0), 1);
    check("add_s0_b", sel_of(fwd_sel, 1), 1);
    cycle(1);
    drive(1, 5, 5, 2'b11, 1, 0, 0, 1, 0, 1);
    check("add_s1_a", sel_of(fwd_sel, 0), 2);
    check("add_s1_b", sel_of(fwd_sel, 1), 2);
    cycle(1);
    drive(1, 5, 5, 2'b11, 1, 0, 0, 1, 0, 1);
    check("add_gone", int'(fwd_sel), 0);
    cycle(1);

    // Nearest stage wins; non-writers do not shadow
    drive(1, 0, 0, 2'b00, 7, 1, 0, 1, 0, 1); cycle(1);
    drive(1, 0, 0, 2'b00, 7, 1, 0, 1, 0, 1); cycle(1);
    drive(1, 7, 0, 2'b01, 0, 0, 0, 1, 0, 1);
    check("nearest", sel_of(fwd_sel, 0), 1);
    cycle(1);
    drive(1, 0, 0, 2'b00, 7, 1, 0, 1, 0, 1); cycle(1);
    drive(1, 0, 0, 2'b00, 7, 0, 0, 1, 0, 1); cycle(1);
    drive(1, 7, 0, 2'b01, 0, 0, 0, 1, 0, 1);
    check("no_shadow", sel_of(fwd_sel, 0), 2);
    cycle(1);

    // Load held in MEM with advance low
    drive(1, 0, 0, 2'b00, 3, 1, 1, 1, 0, 1); cycle(1);
    for (int c = 0; c < 3; c++) begin
      drive(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0);
      check("held_stall", int'(stall), 1);
      cycle(1);
    end
    drive(1, 3, 0, 2'b01, 0, 0, 0, 1, 0, 1);
    check("held_cnt", int'(cnt), 3);
    check("held_rel_stall", int'(stall), 0);
    check("held_rel_sel", sel_of(fwd_sel, 0), 1);
    cycle(1);

    // Load advancing while data not ready: one stall, then forward from WB
    drive(1, 0, 0, 2'b00, 3, 1, 1, 1, 0, 1); cycle(1);
    drive(1, 3, 0, 2'b01, 0, 0, 0, 1, 0, 0);
    check("adv_stall", int'(stall), 1);
    cycle(1);
    drive(1, 3, 0, 2'b01, 0, 0, 0, 1, 0, 0);
    check("adv_nostall", int'(stall), 0);
    check("adv_sel", sel_of(fwd_sel, 0), 2);
    cycle(1);

    // x0 never forwards; a flushed writer is never recorded
    drive(1, 0, 0, 2'b00, 0, 1, 0, 1, 0, 1); cycle(1);
    drive(1, 0, 0, 2'b11, 9, 1, 0, 1, 1, 1);
    check("x0_sel", int'(fwd_sel), 0);
    cycle(1);
    for (int c = 0; c < 2; c++) begin
      drive(1, 9, 9, 2'b11, 0, 0, 0, 1, 0, 1);
      check("flushed_sel", int'(fwd_sel), 0);
      cycle(1);
    end

    // Five more stalls to drive the narrow counter into saturation
    drive(1, 0, 0, 2'b00, 4, 1, 1, 1, 0, 1); cycle(1);
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 4, 2'b10, 0, 0, 0, 0, 0, 0);
      cycle(1);
    end
    drive(1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1);
    check("sat_cnt_s", int'(cnt_s), 3);
    check("wide_cnt", int'(cnt), 9);
    cycle(1);

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      drive(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            2'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 7) == 0), 1'($urandom));
      cycle(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_scoreboard.md
# fwd_hazard_scoreboard

Parametrised forwarding and load-use hazard unit for the 5-stage core, instantiated at the EX stage. Unlike the EX-stage forwarding block, it keeps its own shift-register record of in-flight destination writes: the EX→MEM→WB stages, plus optional extra retire stages. Each cycle it returns per-source forward selects for NUM_SRC operands and a load-use stall for loads whose data is not yet ready. It also keeps a saturating count of stall cycles for performance analysis.

## Interface
- NUM_SRC, 2: number of EX source operands checked.
- NUM_FWD, 2: tracked stages beyond EX. Stage 0 = MEM, stage 1 = WB, higher indices are later.
- SEL_W, $clog2(NUM_FWD+1): width of one forward select.
- CNT_W, 16: stall counter width.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- ex_valid  in  1  EX holds a real instruction.
- ex_rs_addr  in  NUM_SRC*5  source register addresses; source i is at bits [5i+4:5i].
- ex_rs_valid  in  NUM_SRC  source i is actually read.
- ex_rd_addr  in  5  EX destination register.
- ex_rd_wr  in  1  EX instruction writes rd.
- ex_is_load  in  1  EX instruction is a load.
- advance  in  1  pipeline moves one stage this cycle; low = global hold.
- flush  in  1  drop the EX instruction; it is not recorded.
- ld_data_ready  in  1  load data for the stage-0 load is available this cycle.
- fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = register file, k+1 = forward from stage k.
- load_use_stall  out  1  EX must hold; a bubble enters stage 0.
- stall_count  out  CNT_W  saturating count of load_use_stall cycles.

## Operation
- Table: NUM_FWD entries, each holding {v, rd[4:0], wr, ld}.
- An entry is live when v=1, wr=1 and rd≠0.
- Source i is active when ex_valid=1, ex_rs_valid[i]=1 and the address is ≠0.
- Match for source i: the lowest-index live entry k whose rd equals the source address.
  - Nearest stage wins.
  - Entries that are not live never match and never shadow older entries.
- fwd_sel[i]:
  - k+1 on a match;
  - otherwise 0;
  - always 0 when source i is inactive.
- load_use_stall = 1 when any active source has its nearest match at k=0, that entry has ld=1, and ld_data_ready=0.
  - A load match at k≥1 never stalls.
  - All sources are evaluated independently; the stall is their OR.
  - fwd_sel is still driven during a stall. Consumers ignore it.
- Table update when advance=1:
  - entry[k] ← entry[k-1] for k≥1.
  - entry[0] ← {1, ex_rd_addr, ex_rd_wr, ex_is_load} when ex_valid & ~flush & ~load_use_stall.
  - Otherwise entry[0] ← all-zero (bubble).
- Table update when advance=0: the whole table holds. flush and the EX inputs are ignored for table purposes.
- stall_count increments by 1 on each edge where load_use_stall=1. It saturates at 2^CNT_W−1 and never wraps.
- Reset (rst_n=0 at an edge):
  - all entries are cleared to zero and stall_count is cleared to 0;
  - this takes priority over advance and flush;
  - reset asserted in the middle of a stall clears it on the next cycle.

## Timing
- fwd_sel and load_use_stall are purely combinational from the current inputs and table. There are no registered outputs.
- Zero-cycle latency from ex_* and ld_data_ready to the outputs.
- An instruction recorded at edge N is visible as stage 0 during cycle N+1, and as stage k during cycle N+1+k (with advance=1 every cycle).
- Output values after reset:
  - fwd_sel = 0 and load_use_stall = 0 in all cases;
  - stall_count = 0.
- While the table is empty, outputs stay at 0 for any inputs.
- Multi-cycle load with advance=1 each cycle:
  - The stall holds while ld_data_ready=0.
  - Each stalled cycle advances the load to stage 1 and inserts a bubble. The stall therefore releases after at most one cycle, and the data comes from WB (select 2).
- If the pipeline controller keeps the load in MEM, it must drive advance=0. The table then holds, and the stall persists until ld_data_ready=1.
- Simultaneous flush and load_use_stall: a bubble is inserted, and the stall still counts.
- The entry leaving the last stage is discarded. The table has no wrap-around.

## Test plan
- Reset with ex_valid=1, rs1=5, and random data → fwd_sel=0, load_use_stall=0, stall_count=0.
- ADD x5 recorded, then ex_rs1=5, ex_rs2=5 next cycle → fwd_sel={1,1}. After one more advance with a non-writer in between → {2,2}. After a third advance → {0,0}.
- ADD x7 into stage 1 and SUB x7 into stage 0, then read x7 → select 1 (nearest wins). Same test with the stage-0 entry having wr=0 → select 2.
- LW x3 in stage 0, EX reads x3, ld_data_ready=0, advance=0 for 3 cycles → load_use_stall=1 throughout and stall_count=3. Then ld_data_ready=1 → stall=0 and select=1.
- LW x3 in stage 0, ld_data_ready=0, advance=1 → stall for 1 cycle and a bubble enters stage 0. The next cycle gives select=2 and no stall.
- Source x0 with a live x0-writer attempt (rd=0), and flush=1 on an ADD x9 → select 0; x9 is never forwarded afterwards. With CNT_W=2 and 5 stall cycles → stall_count=3.
